exception_redirect_seq: RTL

Sequences the front end after `exception_ctrl` raises `exception_pc_ena`. It holds instruction fetch, tracks in-flight instruction and data bus transactions, and marks stale fetch responses for discard. Once both buses have drained, it delivers a single PC redirect (handler entry `bfc0_0380` or EPC for eret) to the PC stage with a valid/ready handshake. It sits between the LSU-stage exception logic, the fetch unit and the bus interface.

---
 rtl/exception_redirect_seq_pkg.sv | 22 ++
 rtl/exception_redirect_seq_outst_counter.sv | 67 ++++++
 rtl/exception_redirect_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/exception_redirect_seq_pkg.sv
// -----------------------------------------------------------------------------
// exception_redirect_seq_pkg
//   Definitions shared between exception_ctrl and the redirect sequencer:
//   the sequencer state encoding and the exception handler entry vector.
//   This is the single home of those constants; other files import it.
// -----------------------------------------------------------------------------
package exception_redirect_seq_pkg;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } seq_state_e;

    // General exception handler entry point (kseg1, BEV=1 style vector).
    localparam logic [31:0] EXC_HANDLER_PC = 32'hbfc0_0380;

    // Default width of each outstanding-transaction counter.
    localparam int OUTST_W_DEFAULT = 3;

endpackage : exception_redirect_seq_pkg

// File: rtl/exception_redirect_seq_outst_counter.sv
// -----------------------------------------------------------------------------
// outst_counter
//   Tracks how many bus transactions have been requested but not yet
//   answered. One instance watches the instruction bus, another the data bus.
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   asynchronous reset, active low
//     req_fire   in   request handshake completed this cycle
//     resp_fire  in   response handshake completed this cycle
//     cnt        out  registered outstanding count
//     full       out  count is at its maximum (2^OUTST_W-1)
//     err        out  single-cycle pulse: underflow or overflow attempted
// -----------------------------------------------------------------------------
module outst_counter
    import exception_redirect_seq_pkg::*;
#(
    parameter int OUTST_W = OUTST_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_fire,
    input  logic               resp_fire,
    output logic [OUTST_W-1:0] cnt,
    output logic               full,
    output logic               err
);

    localparam logic [OUTST_W-1:0] CNT_MAX  = '1;
    localparam logic [OUTST_W-1:0] CNT_ZERO = '0;

    logic [OUTST_W-1:0] cnt_q;
    logic [OUTST_W-1:0] cnt_d;

    // NOTE: every signal written here gets a default before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        unique case ({req_fire, resp_fire})
            2'b10: begin
                // Saturate instead of wrapping so the drain check never sees
                // a false zero; the caller learns of the overflow via err.
                if (cnt_q == CNT_MAX) err   = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end
            2'b01: begin
                if (cnt_q == CNT_ZERO) err   = 1'b1;
                else                   cnt_d = cnt_q - 1'b1;
            end
            // Idle, or request and response in the same cycle: no change,
            // even at the limits, since the net effect is zero.
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= CNT_ZERO;
        else      cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == CNT_MAX);

endmodule : outst_counter

// File: rtl/exception_redirect_seq.sv
// -----------------------------------------------------------------------------
// exception_redirect_seq
//   Front-end sequencer that runs after exception_ctrl asserts
//   exception_pc_ena. It holds fetch, waits for both the instruction and the
//   data bus to drain, flags stale instruction responses for discard, and
//   finally offers a single PC redirect to the PC stage with valid/ready.
//
//   Ports
//     clk              in   clock, rising edge
//     rst              in   asynchronous reset, active low
//     exc_req          in   exception/eret redirect request
//     exc_pc    [31:0] in   redirect target, valid with exc_req
//     if_req_fire      in   instruction bus request handshake this cycle
//     if_resp_fire     in   instruction bus response handshake this cycle
//     dm_req_fire      in   data bus request handshake this cycle
//     dm_resp_fire     in   data bus response handshake this cycle
//     redirect_ready   in   PC stage accepts the redirect
//     fetch_hold       out  fetch must not issue (registered)
//     if_req_block     out  instruction counter full (combinational)
//     dm_req_block     out  data counter full (combinational)
//     if_resp_discard  out  current instruction response is stale (comb.)
//     redirect_valid   out  redirect_pc is valid (registered)
//     redirect_pc      out  latched redirect target (registered)
//     busy             out  sequencer not idle (registered)
//     protocol_err     out  sticky counter underflow/overflow flag
// -----------------------------------------------------------------------------
module exception_redirect_seq
    import exception_redirect_seq_pkg::*;
#(
    parameter int OUTST_W = OUTST_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        if_req_fire,
    input  logic        if_resp_fire,
    input  logic        dm_req_fire,
    input  logic        dm_resp_fire,
    input  logic        redirect_ready,
    output logic        fetch_hold,
    output logic        if_req_block,
    output logic        dm_req_block,
    output logic        if_resp_discard,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        protocol_err
);

    // ------------------------------------------------------------------
    // Outstanding-transaction tracking
    // ------------------------------------------------------------------
    logic [OUTST_W-1:0] if_cnt;
    logic [OUTST_W-1:0] dm_cnt;
    logic               if_full;
    logic               dm_full;
    logic               if_err;
    logic               dm_err;

    outst_counter #(.OUTST_W(OUTST_W)) u_if_cnt (
        .clk       (clk),
        .rst       (rst),
        .req_fire  (if_req_fire),
        .resp_fire (if_resp_fire),
        .cnt       (if_cnt),
        .full      (if_full),
        .err       (if_err)
    );

    outst_counter #(.OUTST_W(OUTST_W)) u_dm_cnt (
        .clk       (clk),
        .rst       (rst),
        .req_fire  (dm_req_fire),
        .resp_fire (dm_resp_fire),
        .cnt       (dm_cnt),
        .full      (dm_full),
        .err       (dm_err)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    seq_state_e  state_q,          state_d;
    logic [31:0] redirect_pc_q,    redirect_pc_d;
    logic        fetch_hold_q,     fetch_hold_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic        busy_q,           busy_d;
    logic        protocol_err_q,   protocol_err_d;

    logic        buses_idle;
    logic        fire_pending;

    // Registered counts of zero alone are not enough: a fire in this cycle
    // would change them at the edge, so the drain completes only in a
    // cycle that is quiet on both buses.
    assign fire_pending = if_req_fire | if_resp_fire | dm_req_fire | dm_resp_fire;
    assign buses_idle   = (if_cnt == '0) && (dm_cnt == '0) && !fire_pending;

    // Process 1: state register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            redirect_pc_q    <= 32'h0;
            fetch_hold_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            protocol_err_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_pc_q    <= redirect_pc_d;
            fetch_hold_q     <= fetch_hold_d;
            redirect_valid_q <= redirect_valid_d;
            busy_q           <= busy_d;
            protocol_err_q   <= protocol_err_d;
        end
    end

    // Process 2: next state. A new exc_req wins in every state, so the
    // latest target is always the one eventually redirected to.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = exc_req ? exc_pc : redirect_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (exc_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!exc_req && buses_idle) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (exc_req)             state_d = ST_DRAIN;
                else if (redirect_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Process 3: outputs. The registered ones are decoded from the next
    // state so they change on the same edge as the state itself.
    always_comb begin
        fetch_hold_d     = (state_d != ST_IDLE);
        busy_d           = (state_d != ST_IDLE);
        redirect_valid_d = (state_d == ST_REDIRECT);
        protocol_err_d   = protocol_err_q | if_err | dm_err;
    end

    // Any instruction returning once the exception is known belongs to the
    // old stream. Data responses are never dropped: stores must complete.
    assign if_resp_discard = if_resp_fire & (exc_req | (state_q != ST_IDLE));

    assign if_req_block    = if_full;
    assign dm_req_block    = dm_full;
    assign fetch_hold      = fetch_hold_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign busy            = busy_q;
    assign protocol_err    = protocol_err_q;

endmodule : exception_redirect_seq
